// File: rtl/m_cp0.sv
// CP0 coprocessor: SR, Cause, EPC, BadVAddr and PRId with exception/interrupt request.
// Define CP0_COUNT_EN to add the Count/Compare timer that feeds Cause bit 15.
module m_cp0 #(
    parameter logic [31:0] PRID = 32'h0000_2021
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] M_PC,
    input  logic [4:0]  M_ExcCode,
    input  logic        M_BD,
    input  logic [31:0] M_BadVAddr,
    input  logic [5:0]  HWInt,
    input  logic        M_CP0We,
    input  logic [4:0]  M_CP0Addr,
    input  logic [31:0] M_CP0WD,
    input  logic        M_EXLClr,
    output logic [31:0] M_CP0RD,
    output logic [31:0] M_EPCOut,
    output logic        Req
);

    logic [5:0]  im;
    logic        exl;
    logic        ie;
    logic        bd;
    logic [5:0]  ip;
    logic [4:0]  exc_code;
    logic [31:0] epc;
    logic [31:0] bad_vaddr;
    logic        int_req;
    logic        exc_req;
    logic        wr_en;
    logic        ti_now;
    logic [31:0] epc_exc;
    logic [31:0] sr_word;
    logic [31:0] cause_word;

    // Reset gating keeps Req quiet even if the pipeline presents an exception.
    assign int_req = reset_n & (|(ip & im)) & ie & ~exl;
    assign exc_req = reset_n & (M_ExcCode != 5'd0) & ~exl;
    assign Req     = int_req | exc_req;
    assign wr_en   = M_CP0We & ~Req;
    assign epc_exc = M_BD ? (M_PC - 32'd4) : M_PC;

    assign sr_word    = {16'd0, im, 8'd0, exl, ie};
    assign cause_word = {bd, 15'd0, ip, 3'd0, exc_code, 2'd0};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            im        <= '0;
            exl       <= 1'b0;
            ie        <= 1'b0;
            bd        <= 1'b0;
            ip        <= '0;
            exc_code  <= '0;
            epc       <= '0;
            bad_vaddr <= '0;
        end else begin
            ip <= HWInt | {ti_now, 5'd0};
            if (Req) begin
                exl      <= 1'b1;
                bd       <= M_BD;
                epc      <= epc_exc & 32'hFFFF_FFFC;
                exc_code <= int_req ? 5'd0 : M_ExcCode;
                if (!int_req && (M_ExcCode == 5'd4 || M_ExcCode == 5'd5))
                    bad_vaddr <= M_BadVAddr;
            end else begin
                if (wr_en && M_CP0Addr == 5'd12) begin
                    im  <= M_CP0WD[15:10];
                    exl <= M_CP0WD[1];
                    ie  <= M_CP0WD[0];
                end
                if (wr_en && M_CP0Addr == 5'd14)
                    epc <= M_CP0WD & 32'hFFFF_FFFC;
                if (M_EXLClr)
                    exl <= 1'b0;
            end
        end
    end

`ifdef CP0_COUNT_EN
    logic [31:0] count;
    logic [31:0] compare;
    logic        ti;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count   <= '0;
            compare <= '0;
            ti      <= 1'b0;
        end else begin
            if (wr_en && M_CP0Addr == 5'd9)
                count <= M_CP0WD;
            else
                count <= count + 32'd1;
            // A Compare write acknowledges the timer and beats a same-cycle match.
            if (wr_en && M_CP0Addr == 5'd11) begin
                compare <= M_CP0WD;
                ti      <= 1'b0;
            end else if (count == compare && compare != 32'd0) begin
                ti <= 1'b1;
            end
        end
    end

    assign ti_now = ti;
`else
    assign ti_now = 1'b0;
`endif

    always_comb begin
        M_CP0RD = 32'd0;
        case (M_CP0Addr)
            5'd8:    M_CP0RD = bad_vaddr;
`ifdef CP0_COUNT_EN
            5'd9:    M_CP0RD = count;
            5'd11:   M_CP0RD = compare;
`endif
            5'd12:   M_CP0RD = sr_word;
            5'd13:   M_CP0RD = cause_word;
            5'd14:   M_CP0RD = epc;
            5'd15:   M_CP0RD = PRID;
            default: M_CP0RD = 32'd0;
        endcase
    end

    assign M_EPCOut = (wr_en && M_CP0Addr == 5'd14)
                    ? (M_CP0WD & 32'hFFFF_FFFC) : epc;

endmodule

// File: tb/tb_m_cp0.sv
// Self-checking bench for m_cp0: directed scenarios plus random traffic
// against a register-level reference model.
module tb_m_cp0;

    localparam logic [31:0] PRID = 32'h0000_2021;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] M_PC;
    logic [4:0]  M_ExcCode;
    logic        M_BD;
    logic [31:0] M_BadVAddr;
    logic [5:0]  HWInt;
    logic        M_CP0We;
    logic [4:0]  M_CP0Addr;
    logic [31:0] M_CP0WD;
    logic        M_EXLClr;
    logic [31:0] M_CP0RD;
    logic [31:0] M_EPCOut;
    logic        Req;

    int n_checks = 0;
    int n_fail   = 0;

    m_cp0 #(.PRID(PRID)) dut (
        .clk(clk), .reset_n(reset_n), .M_PC(M_PC), .M_ExcCode(M_ExcCode),
        .M_BD(M_BD), .M_BadVAddr(M_BadVAddr), .HWInt(HWInt),
        .M_CP0We(M_CP0We), .M_CP0Addr(M_CP0Addr), .M_CP0WD(M_CP0WD),
        .M_EXLClr(M_EXLClr), .M_CP0RD(M_CP0RD), .M_EPCOut(M_EPCOut), .Req(Req)
    );

    always #5 clk = ~clk;

    // Reference model: architectural register words.
    logic [31:0] r_sr, r_cause, r_epc, r_bad, r_cnt, r_cmp;
    logic        r_ti;
    logic [5:0]  r_ip;

    function automatic logic model_int();
        return (|(r_ip & r_sr[15:10])) && r_sr[0] && !r_sr[1];
    endfunction

    function automatic logic model_req();
        return model_int() || (M_ExcCode != 5'd0 && !r_sr[1]);
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (a)
            5'd8:  return r_bad;
`ifdef CP0_COUNT_EN
            5'd9:  return r_cnt;
            5'd11: return r_cmp;
`endif
            5'd12: return r_sr;
            5'd13: return r_cause;
            5'd14: return r_epc;
            5'd15: return PRID;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        r_sr = 0; r_cause = 0; r_epc = 0; r_bad = 0;
        r_cnt = 0; r_cmp = 0; r_ti = 0; r_ip = 0;
    endtask

    task automatic model_step();
        logic intr, req, wr;
        logic [31:0] n_sr, n_cause, n_epc, n_bad, n_cnt, n_cmp;
        logic n_ti;
        logic [5:0] n_ip;
        intr = model_int();
        req  = model_req();
        wr   = M_CP0We && !req;
        n_sr = r_sr; n_cause = r_cause; n_epc = r_epc; n_bad = r_bad;
        n_cnt = r_cnt; n_cmp = r_cmp; n_ti = r_ti;
        if (req) begin
            n_sr    = r_sr | 32'h2;
            n_cause = {M_BD, 31'd0} | {25'd0, (intr ? 5'd0 : M_ExcCode), 2'd0};
            n_epc   = (M_BD ? M_PC - 32'd4 : M_PC) & ~32'h3;
            if (!intr && (M_ExcCode == 5'd4 || M_ExcCode == 5'd5))
                n_bad = M_BadVAddr;
        end else begin
            if (wr && M_CP0Addr == 5'd12) n_sr = M_CP0WD & 32'h0000_FC03;
            if (wr && M_CP0Addr == 5'd14) n_epc = M_CP0WD & ~32'h3;
            if (M_EXLClr) n_sr = n_sr & ~32'h2;
        end
`ifdef CP0_COUNT_EN
        n_cnt = (wr && M_CP0Addr == 5'd9) ? M_CP0WD : r_cnt + 32'd1;
        if (wr && M_CP0Addr == 5'd11) begin
            n_cmp = M_CP0WD;
            n_ti  = 1'b0;
        end else if (r_cnt == r_cmp && r_cmp != 0) begin
            n_ti = 1'b1;
        end
        n_ip = HWInt | {r_ti, 5'd0};
`else
        n_ip = HWInt;
`endif
        n_cause[15:10] = n_ip;
        r_sr = n_sr; r_cause = n_cause; r_epc = n_epc; r_bad = n_bad;
        r_cnt = n_cnt; r_cmp = n_cmp; r_ti = n_ti; r_ip = n_ip;
    endtask

    task automatic idle();
        M_PC = 0; M_ExcCode = 0; M_BD = 0; M_BadVAddr = 0; HWInt = 0;
        M_CP0We = 0; M_CP0Addr = 0; M_CP0WD = 0; M_EXLClr = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        logic [4:0] addrs [6];
        logic [31:0] want;
        addrs = '{5'd8, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3};
        do_reset();
        reset_n = 1'b0;
        M_ExcCode = 5'd12; HWInt = 6'h3f;
        tick();
        n_checks++;
        if (Req !== 1'b0) begin
            $display("FAIL reset_req: got %b want 0", Req); n_fail++;
        end
        for (int i = 0; i < 6; i++) begin
            M_CP0Addr = addrs[i];
            #1;
            want = (addrs[i] == 5'd15) ? PRID : 32'd0;
            n_checks++;
            if (M_CP0RD !== want) begin
                $display("FAIL reset_rd%0d: got %h want %h", addrs[i], M_CP0RD, want);
                n_fail++;
            end
        end
        do_reset();
    endtask

    task automatic test_exc_ov();
        do_reset();
        M_ExcCode = 5'd12; M_PC = 32'h3010; M_BD = 0;
        #1;
        n_checks++;
        if (Req !== 1'b1) begin
            $display("FAIL ov_req: got %b want 1", Req); n_fail++;
        end
        tick();
        idle();
        M_CP0Addr = 5'd14; #1;
        n_checks++;
        if (M_CP0RD !== 32'h3010) begin
            $display("FAIL ov_epc: got %h want 00003010", M_CP0RD); n_fail++;
        end
        M_CP0Addr = 5'd13; #1;
        n_checks++;
        if (M_CP0RD[6:2] !== 5'd12) begin
            $display("FAIL ov_code: got %0d want 12", M_CP0RD[6:2]); n_fail++;
        end
        M_CP0Addr = 5'd12; #1;
        n_checks++;
        if (M_CP0RD !== 32'h2) begin
            $display("FAIL ov_sr: got %h want 00000002", M_CP0RD); n_fail++;
        end
    endtask

    task automatic test_adel_bd();
        do_reset();
        M_ExcCode = 5'd4; M_BD = 1; M_PC = 32'h3024; M_BadVAddr = 32'h1003;
        tick();
        idle();
        M_CP0Addr = 5'd14; #1;
        n_checks++;
        if (M_CP0RD !== 32'h3020) begin
            $display("FAIL adel_epc: got %h want 00003020", M_CP0RD); n_fail++;
        end
        M_CP0Addr = 5'd13; #1;
        n_checks++;
        if (M_CP0RD !== 32'h8000_0010) begin
            $display("FAIL adel_cause: got %h want 80000010", M_CP0RD); n_fail++;
        end
        M_CP0Addr = 5'd8; #1;
        n_checks++;
        if (M_CP0RD !== 32'h1003) begin
            $display("FAIL adel_bad: got %h want 00001003", M_CP0RD); n_fail++;
        end
    endtask

    task automatic test_int_priority();
        logic [4:0] codes [2];
        codes = '{5'd10, 5'd4};
        for (int i = 0; i < 2; i++) begin
            do_reset();
            M_CP0We = 1; M_CP0Addr = 5'd12; M_CP0WD = 32'h0000_0401; HWInt = 6'h01;
            tick();
            M_CP0We = 0;
            M_ExcCode = codes[i]; M_PC = 32'h3100; M_BadVAddr = 32'hDEAD_BEE0;
            #1;
            n_checks++;
            if (Req !== 1'b1) begin
                $display("FAIL int_req%0d: got %b want 1", codes[i], Req); n_fail++;
            end
            tick();
            idle();
            M_CP0Addr = 5'd13; #1;
            n_checks++;
            if (M_CP0RD[6:2] !== 5'd0) begin
                $display("FAIL int_code%0d: got %0d want 0", codes[i], M_CP0RD[6:2]);
                n_fail++;
            end
            M_CP0Addr = 5'd8; #1;
            n_checks++;
            if (M_CP0RD !== 32'd0) begin
                $display("FAIL int_bad%0d: got %h want 0", codes[i], M_CP0RD); n_fail++;
            end
        end
    endtask

    task automatic test_exl_block();
        do_reset();
        M_ExcCode = 5'd12; M_PC = 32'h3010;
        tick();
        M_ExcCode = 5'd5; M_PC = 32'h4000; M_BadVAddr = 32'h5555;
        #1;
        n_checks++;
        if (Req !== 1'b0) begin
            $display("FAIL exl_req: got %b want 0", Req); n_fail++;
        end
        tick();
        idle();
        M_CP0Addr = 5'd14; #1;
        n_checks++;
        if (M_CP0RD !== 32'h3010) begin
            $display("FAIL exl_epc: got %h want 00003010", M_CP0RD); n_fail++;
        end
        M_CP0Addr = 5'd8; #1;
        n_checks++;
        if (M_CP0RD !== 32'd0) begin
            $display("FAIL exl_bad: got %h want 0", M_CP0RD); n_fail++;
        end
        M_EXLClr = 1;
        tick();
        M_EXLClr = 0;
        M_CP0Addr = 5'd12; #1;
        n_checks++;
        if (M_CP0RD !== 32'd0) begin
            $display("FAIL eret_sr: got %h want 0", M_CP0RD); n_fail++;
        end
        M_CP0We = 1; M_CP0Addr = 5'd14; M_CP0WD = 32'h3047;
        #1;
        n_checks++;
        if (M_EPCOut !== 32'h3044) begin
            $display("FAIL epc_bypass: got %h want 00003044", M_EPCOut); n_fail++;
        end
        tick();
        M_CP0We = 0; #1;
        n_checks++;
        if (M_CP0RD !== 32'h3044) begin
            $display("FAIL epc_wr: got %h want 00003044", M_CP0RD); n_fail++;
        end
    endtask

    task automatic test_mtc0();
        do_reset();
        M_CP0We = 1; M_CP0Addr = 5'd12; M_CP0WD = 32'hFFFF_FFFF;
        tick();
        M_CP0We = 0; #1;
        n_checks++;
        if (M_CP0RD !== 32'h0000_FC03) begin
            $display("FAIL sr_mask: got %h want 0000fc03", M_CP0RD); n_fail++;
        end
        do_reset();
        M_CP0We = 1; M_CP0Addr = 5'd12; M_CP0WD = 32'h0000_0401; M_ExcCode = 5'd10;
        tick();
        idle();
        M_CP0Addr = 5'd12; #1;
        n_checks++;
        if (M_CP0RD !== 32'h2) begin
            $display("FAIL sr_suppress: got %h want 00000002", M_CP0RD); n_fail++;
        end
        do_reset();
        M_CP0We = 1; M_CP0Addr = 5'd13; M_CP0WD = 32'hFFFF_FFFF;
        tick();
        M_CP0Addr = 5'd15; M_CP0WD = 32'h1234_5678;
        tick();
        M_CP0We = 0; #1;
        n_checks++;
        if (M_CP0RD !== PRID) begin
            $display("FAIL prid_ro: got %h want %h", M_CP0RD, PRID); n_fail++;
        end
        M_CP0Addr = 5'd13; #1;
        n_checks++;
        if (M_CP0RD !== 32'd0) begin
            $display("FAIL cause_ro: got %h want 0", M_CP0RD); n_fail++;
        end
    endtask

`ifdef CP0_COUNT_EN
    task automatic test_timer();
        logic seen;
        do_reset();
        M_CP0We = 1; M_CP0Addr = 5'd11; M_CP0WD = 32'd5;
        tick();
        M_CP0Addr = 5'd12; M_CP0WD = 32'h0000_8001;
        tick();
        idle();
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            #1;
            if (Req === 1'b1) seen = 1;
            else tick();
        end
        n_checks++;
        if (!seen) begin
            $display("FAIL timer_req: got no Req within 20 cycles"); n_fail++;
        end
        M_CP0Addr = 5'd13; #1;
        n_checks++;
        if (M_CP0RD[15] !== 1'b1) begin
            $display("FAIL timer_ip: got %b want 1", M_CP0RD[15]); n_fail++;
        end
        tick();
        M_CP0We = 1; M_CP0Addr = 5'd11; M_CP0WD = 32'h100;
        tick();
        M_CP0We = 0;
        tick();
        M_CP0Addr = 5'd13; #1;
        n_checks++;
        if (M_CP0RD[15] !== 1'b0) begin
            $display("FAIL timer_clr: got %b want 0", M_CP0RD[15]); n_fail++;
        end
        M_CP0We = 1; M_CP0Addr = 5'd9; M_CP0WD = 32'd100;
        tick();
        M_CP0We = 0; #1;
        n_checks++;
        if (M_CP0RD !== 32'd100) begin
            $display("FAIL count_ld: got %0d want 100", M_CP0RD); n_fail++;
        end
        tick();
        n_checks++;
        if (M_CP0RD !== 32'd101) begin
            $display("FAIL count_inc: got %0d want 101", M_CP0RD); n_fail++;
        end
    endtask
`else
    task automatic test_no_count();
        do_reset();
        M_CP0We = 1; M_CP0Addr = 5'd9; M_CP0WD = 32'h55;
        tick();
        M_CP0We = 0; #1;
        n_checks++;
        if (M_CP0RD !== 32'd0) begin
            $display("FAIL count_off: got %h want 0", M_CP0RD); n_fail++;
        end
        M_CP0We = 1; M_CP0Addr = 5'd11; M_CP0WD = 32'h66;
        tick();
        M_CP0We = 0; #1;
        n_checks++;
        if (M_CP0RD !== 32'd0) begin
            $display("FAIL compare_off: got %h want 0", M_CP0RD); n_fail++;
        end
    endtask
`endif

    task automatic test_random();
        logic [4:0] codes [11];
        logic [4:0] addrs [9];
        logic exp_req;
        logic [31:0] exp_rd, exp_epc;
        codes = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd5, 5'd10, 5'd12, 5'd8};
        addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd0, 5'd3};
        do_reset();
        for (int c = 0; c < 600; c++) begin
            M_ExcCode  = codes[$urandom_range(0, 10)];
            M_PC       = $urandom;
            M_BD       = 1'($urandom_range(0, 1));
            M_BadVAddr = $urandom;
            HWInt      = ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'd0;
            M_CP0We    = ($urandom_range(0, 9) < 3);
            M_CP0Addr  = addrs[$urandom_range(0, 8)];
            M_CP0WD    = (M_CP0Addr == 5'd9 || M_CP0Addr == 5'd11)
                       ? 32'($urandom_range(0, 40)) : $urandom;
            M_EXLClr   = ($urandom_range(0, 6) == 0);
            #1;
            exp_req = model_req();
            exp_rd  = model_read(M_CP0Addr);
            exp_epc = (M_CP0We && !exp_req && M_CP0Addr == 5'd14)
                    ? (M_CP0WD & ~32'h3) : r_epc;
            n_checks++;
            if (Req !== exp_req) begin
                $display("FAIL rnd_req c%0d: got %b want %b", c, Req, exp_req); n_fail++;
            end
            n_checks++;
            if (M_CP0RD !== exp_rd) begin
                $display("FAIL rnd_rd%0d c%0d: got %h want %h", M_CP0Addr, c, M_CP0RD, exp_rd);
                n_fail++;
            end
            n_checks++;
            if (M_EPCOut !== exp_epc) begin
                $display("FAIL rnd_epcout c%0d: got %h want %h", c, M_EPCOut, exp_epc);
                n_fail++;
            end
            model_step();
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        reset_n = 1'b0;
        model_reset();
        test_reset();
        test_exc_ov();
        test_adel_bd();
        test_int_priority();
        test_exl_block();
        test_mtc0();
`ifdef CP0_COUNT_EN
        test_timer();
`else
        test_no_count();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
